// File: rtl/shift_op_sequencer.sv
// Multi-cycle shifter-operand sequencer: latches IR/Rs/Rm/C, shifts STEP bits per clock.
// Build option: define SHIFT_FASTPATH_EN to resolve amounts >= 32 without iterating.
module shift_op_sequencer #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] IR,
  input  logic [31:0] Rs,
  input  logic [31:0] Rm,
  input  logic        SR29_IN,
  output logic        busy,
  output logic        done,
  output logic [31:0] Out,
  output logic        SR29_OUT
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned AW = 9;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIX, S_DONE} state_e;
  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shtype_e;
  typedef enum logic [1:0] {FX_NONE, FX_ZERO, FX_RRX, FX_MSB} fix_e;

  state_e          state_q, state_d;
  shtype_e         type_q;
  fix_e            fix_q;
  logic [DW-1:0]   work_q;
  logic            carry_q;
  logic [CW-1:0]   rem_q;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   out_q, out_d;
  logic            c_q, c_d;

  shtype_e         dec_type;
  fix_e            dec_fix;
  logic [DW-1:0]   dec_work;
  logic            dec_carry;
  logic [CW-1:0]   dec_count;
  logic [AW-1:0]   amount;
  logic            shift_en;

  logic [DW-1:0]   step_work;
  logic            step_carry;
  logic [CW-1:0]   step_rem;

  logic            unused_bits;
  assign unused_bits = ^{IR[31:28], Rs[31:8]};

  assign busy     = busy_q;
  assign done     = done_q;
  assign Out      = out_q;
  assign SR29_OUT = c_q;

  // Operand decode: initial working value, carry, shift type, iteration count and fix-up kind
  always_comb begin
    dec_work  = Rm;
    dec_carry = SR29_IN;
    dec_type  = shtype_e'(IR[6:5]);
    dec_fix   = FX_NONE;
    dec_count = '0;
    amount    = '0;
    shift_en  = 1'b0;
    unique case (IR[27:25])
      3'b000, 3'b011: begin
        if ((IR[27:25] == 3'b000) && IR[4]) begin
          amount   = AW'(Rs[7:0]);
          shift_en = (Rs[7:0] != 8'd0);
        end else if (IR[11:7] == 5'd0) begin
          unique case (dec_type)
            SH_LSR, SH_ASR: begin
              amount   = AW'(DW);
              shift_en = 1'b1;
            end
            SH_ROR:  dec_fix = FX_RRX;
            default: ;
          endcase
        end else begin
          amount   = AW'(IR[11:7]);
          shift_en = 1'b1;
        end
      end
      3'b001: begin
        dec_work = DW'(IR[7:0]);
        dec_type = SH_ROR;
        amount   = AW'({IR[11:8], 1'b0});
        shift_en = (IR[11:8] != 4'd0);
      end
      3'b010:  dec_work = DW'(IR[11:0]);
      3'b101:  dec_work = {{6{IR[23]}}, IR[23:0], 2'b00};
      default: ;
    endcase

    if (shift_en) begin
      if (dec_type == SH_ROR) begin
        // Rotate by a multiple of 32 leaves the value intact; carry is then bit 31
        dec_count = CW'(amount[4:0]);
        dec_fix   = FX_MSB;
      end else if (amount >= AW'(DW)) begin
`ifdef SHIFT_FASTPATH_EN
        dec_count = '0;
        unique case (dec_type)
          SH_LSL: begin
            dec_work  = '0;
            dec_carry = (amount == AW'(DW)) ? Rm[0] : 1'b0;
          end
          SH_LSR: begin
            dec_work  = '0;
            dec_carry = (amount == AW'(DW)) ? Rm[DW-1] : 1'b0;
          end
          default: begin
            dec_work  = {DW{Rm[DW-1]}};
            dec_carry = Rm[DW-1];
          end
        endcase
`else
        dec_count = CW'(DW);
        if ((amount > AW'(DW)) && (dec_type != SH_ASR)) dec_fix = FX_ZERO;
`endif
      end else begin
        dec_count = CW'(amount[4:0]);
      end
    end
  end

  // Up to STEP single-bit shifts per clock, stopping when the count runs out
  always_comb begin
    step_work  = work_q;
    step_carry = carry_q;
    step_rem   = rem_q;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (step_rem != '0) begin
        unique case (type_q)
          SH_LSL: begin
            step_carry = step_work[DW-1];
            step_work  = {step_work[DW-2:0], 1'b0};
          end
          SH_LSR: begin
            step_carry = step_work[0];
            step_work  = {1'b0, step_work[DW-1:1]};
          end
          SH_ASR: begin
            step_carry = step_work[0];
            step_work  = {step_work[DW-1], step_work[DW-1:1]};
          end
          default: begin
            step_carry = step_work[0];
            step_work  = {step_work[0], step_work[DW-1:1]};
          end
        endcase
        step_rem = step_rem - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (dec_count != '0) ? S_SHIFT : S_FIX;
      S_SHIFT: if (step_rem == '0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered handshake and result; result is only written on the FIX edge
  always_comb begin
    busy_d = (state_d == S_SHIFT) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
    out_d  = out_q;
    c_d    = c_q;
    if (state_q == S_FIX) begin
      unique case (fix_q)
        FX_NONE: begin
          out_d = work_q;
          c_d   = carry_q;
        end
        FX_ZERO: begin
          out_d = '0;
          c_d   = 1'b0;
        end
        FX_RRX: begin
          out_d = {carry_q, work_q[DW-1:1]};
          c_d   = work_q[0];
        end
        default: begin
          out_d = work_q;
          c_d   = work_q[DW-1];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      type_q  <= SH_LSL;
      fix_q   <= FX_NONE;
      work_q  <= '0;
      carry_q <= 1'b0;
      rem_q   <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      type_q  <= dec_type;
      fix_q   <= dec_fix;
      work_q  <= dec_work;
      carry_q <= dec_carry;
      rem_q   <= dec_count;
    end else if (state_q == S_SHIFT) begin
      work_q  <= step_work;
      carry_q <= step_carry;
      rem_q   <= step_rem;
    end
  end

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Bench for shift_op_sequencer: directed cases, random ops against an arithmetic model, reset abort.
module tb_shift_op_sequencer;

  localparam int STEP = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] IR, Rs, Rm;
  logic        SR29_IN;
  logic        busy, done;
  logic [31:0] Out;
  logic        SR29_OUT;

  int total = 0;
  int bad   = 0;

  shift_op_sequencer #(.STEP(STEP)) dut (
    .clk(clk), .reset(reset), .start(start), .IR(IR), .Rs(Rs), .Rm(Rm),
    .SR29_IN(SR29_IN), .busy(busy), .done(done), .Out(Out), .SR29_OUT(SR29_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] imm_ir(input logic [1:0] ty, input logic [4:0] amt);
    return 32'hE1A0_0000 | (32'(amt) << 7) | (32'(ty) << 5);
  endfunction

  function automatic logic [31:0] reg_ir(input logic [1:0] ty);
    return 32'hE1A0_0010 | (32'(ty) << 5);
  endfunction

  // Reference: ARM shifter-operand semantics computed on 64-bit values
  task automatic model(input logic [31:0] ir, input logic [31:0] rs, input logic [31:0] rm,
                       input logic cin, output logic [31:0] o, output logic c, output int lat);
    int unsigned amt, cnt, r;
    logic [1:0] ty;
    logic [31:0] v;
    logic [63:0] w;
    logic signed [63:0] sw;
    bit is_reg, do_shift;
    o = rm; c = cin; cnt = 0; amt = 0; do_shift = 0;
    ty = ir[6:5];
    v = rm;
    is_reg = (ir[27:25] == 3'b000) && ir[4];
    case (ir[27:25])
      3'b000, 3'b011: begin
        if (is_reg) amt = int'(rs[7:0]);
        else begin
          amt = int'(ir[11:7]);
          if (amt == 0 && (ty == 2'd1 || ty == 2'd2)) amt = 32;
        end
        if (!is_reg && ty == 2'd3 && amt == 0) begin
          o = {cin, rm[31:1]};
          c = rm[0];
        end else do_shift = (amt != 0);
      end
      3'b001: begin
        ty = 2'd3;
        amt = 2 * int'(ir[11:8]);
        v = 32'(ir[7:0]);
        o = v;
        do_shift = (amt != 0);
      end
      3'b010: o = 32'(ir[11:0]);
      3'b101: o = {{8{ir[23]}}, ir[23:0]} << 2;
      default: ;
    endcase
    if (do_shift) begin
      case (ty)
        2'd0: begin w = {32'd0, v} << amt; o = w[31:0]; c = w[32]; end
        2'd1: begin w = {v, 32'd0} >> amt; o = w[63:32]; c = w[31]; end
        2'd2: begin sw = {v, 32'd0}; sw = sw >>> amt; o = sw[63:32]; c = sw[31]; end
        default: begin
          r = amt % 32;
          if (r == 0) begin o = v; c = v[31]; end
          else begin o = (v >> r) | (v << (32 - r)); c = o[31]; end
        end
      endcase
      if (ty == 2'd3) cnt = amt % 32;
      else begin
        cnt = (amt > 32) ? 32 : amt;
`ifdef SHIFT_FASTPATH_EN
        if (amt >= 32) cnt = 0;
`endif
      end
    end
    lat = 2 + (int'(cnt) + STEP - 1) / STEP;
  endtask

  task automatic run_op(input string tag, input logic [31:0] ir, input logic [31:0] rs,
                        input logic [31:0] rm, input logic cin, input bit hold,
                        input logic [31:0] exp_out, input logic exp_c, input int exp_lat);
    int lat;
    @(negedge clk);
    IR = ir; Rs = rs; Rm = rm; SR29_IN = cin; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    IR = $urandom; Rs = $urandom; Rm = $urandom; SR29_IN = ~cin;
    chk({tag, ".busy_on"}, 32'(busy), 32'd1);
    lat = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      if (done) begin lat = cyc + 1; break; end
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".out"}, Out, exp_out);
    chk({tag, ".c"}, 32'(SR29_OUT), 32'(exp_c));
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".out_hold"}, Out, exp_out);
  endtask

  initial begin
    logic [31:0] ir, rs, rm, eo;
    logic ci, ec;
    int el, fast_lat, ndone;
    logic [2:0] cls;

`ifdef SHIFT_FASTPATH_EN
    fast_lat = 2;
`else
    fast_lat = 10;
`endif

    reset = 1'b1; start = 1'b0; IR = '0; Rs = '0; Rm = '0; SR29_IN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.out", Out, 32'd0);
    chk("reset.c", 32'(SR29_OUT), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("lsl5", imm_ir(2'd0, 5'd5), 32'd0, 32'h8000_0001, 1'b0, 1'b0, 32'h0000_0020, 1'b0, 4);
    run_op("lsr_r32", reg_ir(2'd1), 32'd32, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, fast_lat);
    run_op("lsr_r40", reg_ir(2'd1), 32'd40, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 1'b0, fast_lat);
    run_op("asr0", imm_ir(2'd2, 5'd0), 32'd0, 32'h8000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, fast_lat);
    run_op("rrx", imm_ir(2'd3, 5'd0), 32'd0, 32'h0000_0003, 1'b1, 1'b0, 32'h8000_0001, 1'b1, 2);
    run_op("rot_imm", 32'hE3A0_04FF, 32'd0, 32'h1234_5678, 1'b0, 1'b0, 32'hFF00_0000, 1'b1, 4);
    run_op("ror_r64", reg_ir(2'd3), 32'd64, 32'h8000_0001, 1'b0, 1'b0, 32'h8000_0001, 1'b1, 2);
    run_op("lsl_r0", reg_ir(2'd0), 32'h0000_0100, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 2);
    run_op("asr_r200", reg_ir(2'd2), 32'd200, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0, fast_lat);
    run_op("hold", imm_ir(2'd0, 5'd5), 32'd0, 32'h0800_0003, 1'b0, 1'b1, 32'h0000_0060, 1'b1, 4);

    for (int n = 0; n < 40; n++) begin
      ir = $urandom;
      case ($urandom_range(0, 7))
        0, 1:    cls = 3'b000;
        2:       cls = 3'b001;
        3:       cls = 3'b010;
        4:       cls = 3'b011;
        5:       cls = 3'b101;
        6:       cls = 3'b000;
        default: cls = 3'b111;
      endcase
      ir[27:25] = cls;
      rs = $urandom;
      case ($urandom_range(0, 7))
        0: rs[7:0] = 8'd0;
        1: rs[7:0] = 8'd32;
        2: rs[7:0] = 8'd33;
        3: rs[7:0] = 8'd64;
        4: rs[7:0] = 8'd31;
        default: rs[7:0] = 8'($urandom_range(0, 40));
      endcase
      rm = $urandom;
      ci = 1'($urandom);
      model(ir, rs, rm, ci, eo, ec, el);
      run_op("rand", ir, rs, rm, ci, 1'b0, eo, ec, el);
    end

    // Abort a long shift with reset: no done may follow and outputs clear
    @(negedge clk);
    IR = imm_ir(2'd0, 5'd31); Rm = 32'hFFFF_FFFF; SR29_IN = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.out", Out, 32'd0);
    chk("abort.c", 32'(SR29_OUT), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort.no_done", 32'(ndone), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_op_sequencer.md
Name: shift_op_sequencer

Overview:
- Multi-cycle shifter-operand controller for the execute stage.
- On a start pulse it latches IR, Rs, Rm and the carry flag, then decodes the instruction class and shifter operand: shift type, amount, value and special encodings.
- It performs the shift iteratively, STEP bits per clock, and returns the 32-bit operand plus shifter carry-out with a busy/done handshake.
- It replaces single-cycle combinational shifting where timing closure needs the shift split over several cycles.

Parameters:
STEP, 4, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8, 16, 32.

Ports:
clk  input  1  clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only while busy=0
IR  input  32  instruction word
Rs  input  32  shift-amount register value
Rm  input  32  shift-source register value
SR29_IN  input  1  current C flag
busy  output  1  high from the accepting edge until done
done  output  1  one-cycle pulse; Out/SR29_OUT valid
Out  output  32  shifter operand result, held until the next accepted start
SR29_OUT  output  1  shifter carry-out, held with Out

Behaviour:
- Reset (synchronous, active-high reset; single clock clk):
  - Clears all outputs: busy=0, done=0, Out=0, SR29_OUT=0.
  - FSM goes to IDLE.
  - Takes effect on any edge, including mid-operation; the in-flight operation is discarded and no done is issued.
- FSM states: IDLE, SHIFT, FIX, DONE.
- IDLE, start=1 at an edge:
  - Latches IR, Rs, Rm, SR29_IN and decodes; busy=1.
  - Next state is SHIFT if the effective count is >0, otherwise FIX.
  - start while busy=1 is ignored (not queued).
- Decode by IR[27:25]:
  - 000 with IR[4]=0, and 011: value Rm, type IR[6:5], amount IR[11:7].
    - LSL #0 gives Out=Rm, C=SR29_IN.
    - LSR #0 and ASR #0 mean amount 32.
    - ROR #0 means RRX: Out={SR29_IN,Rm[31:1]}, C=Rm[0]; handled in FIX.
  - 000 with IR[4]=1: value Rm, type IR[6:5], amount Rs[7:0].
    - Amount 0 gives Out=Rm, C=SR29_IN.
  - 001: value zero-extended IR[7:0], type ROR, amount IR[11:8]*2.
    - Amount 0 gives C=SR29_IN.
  - 010: Out=zero-extended IR[11:0], C=SR29_IN; no shifting.
  - 101: Out=sign-extended IR[23:0]<<2, C=SR29_IN; no shifting.
  - Other classes: Out=Rm, C=SR29_IN.
- Effective count:
  - LSL/LSR/ASR: min(amount,32).
  - ROR: amount mod 32.
  - ROR with nonzero amount and amount[4:0]=0: count 0, resolved in FIX as Out=Rm, C=Rm[31].
- SHIFT state:
  - Each edge shifts the working register by k=min(STEP,remaining) and decrements remaining by k.
  - Carry register takes the last bit shifted out.
  - LSL fills 0; LSR fills 0; ASR fills the sign bit; ROR rotates.
  - Goes to FIX when remaining reaches 0.
- FIX state (one edge): applies the special cases.
  - LSL/LSR with amount>32: Out=0, C=0.
  - RRX and ROR-multiple-of-32 as defined above.
  - Register ROR by a nonzero count: C=result[31].
  - Writes Out/SR29_OUT.
  - Goes to DONE.
- DONE state: done=1 and busy=0 for exactly one cycle, then IDLE.
  - A start sampled during DONE is ignored.
- Latency, accepting edge to done high: 2 + ceil(count/STEP) cycles.
  - Example: count 0 gives 2 cycles.
  - Example: STEP=4 with LSL #5 gives 4 cycles.

Optional Feature:
- SHIFT_FASTPATH_EN defined:
  - Operations whose amount is ≥32 (non-ROR) or whose effective count is 0 skip SHIFT; FIX results are computed directly.
  - Ops with amount ≥32 therefore complete in 2 cycles.
- Not defined:
  - Amounts ≥32 iterate the full 32 bits.
- Results are identical in both builds; only latency differs.

Test Plan:
- STEP=4, IR class 000 immediate LSL #5, Rm=32'h8000_0001, C_IN=0 → after 4 cycles done pulse, Out=32'h0000_0020, SR29_OUT=0.
- Register LSR, Rs=32, Rm=32'h8000_0000 → Out=0, SR29_OUT=1; with Rs=40 → Out=0, SR29_OUT=0; latency 10 cycles without fastpath, 2 with SHIFT_FASTPATH_EN.
- Immediate ASR #0 (amount 32), Rm=32'h8000_0000 → Out=32'hFFFF_FFFF, SR29_OUT=1.
- Immediate ROR #0 (RRX), Rm=32'h0000_0003, C_IN=1 → Out=32'h8000_0001, SR29_OUT=1.
- Class 001, IR[11:0]=12'h4FF → Out=32'hFF00_0000, SR29_OUT=1.
- Reset asserted during SHIFT of a 32-bit shift → next cycle busy=0, done never pulses, Out=0; start held high during busy → only one done.
